// File: rtl/mem_byte_ctrl_if.sv
// Request/response handshake between a requester and the byte-serial memory controller.
interface mem_byte_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;

   modport master (
      output req_valid, req_we, req_size, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_size, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/mem_byte_ctrl.sv
// Splits byte/half/word requests into byte-wide memory accesses, with IO write
// throttling, global freeze (rdy_in) and read abort (flush_pipline).
module mem_byte_ctrl (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  flush_pipline,
   mem_byte_ctrl_if.slave        bus,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [31:0]           mem_a,
   output logic                  mem_wr,
   input  logic                  io_buffer_full,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state, state_nx;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [2:0]  len_q, idx_q;
   logic        cap_vld_q;
   logic [1:0]  cap_idx_q;
   logic        io_last_q;

   logic [31:0] byte_addr;
   logic        is_io;
   logic        issue_rd, issue_wr;
   logic        start;
   logic [2:0]  req_len;

   assign byte_addr     = addr_q + {29'd0, idx_q};
   assign is_io         = (byte_addr[17:16] == 2'b11);
   assign bus.req_ready = (state == IDLE) && rdy_in && !flush_pipline && !rst_in;
   assign busy          = (state != IDLE);
   assign start         = bus.req_valid && bus.req_ready;

   always_comb begin
      case (bus.req_size)
         2'd0:    req_len = 3'd1;
         2'd1:    req_len = 3'd2;
         default: req_len = 3'd4;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_nx;
   end

   // Nothing is issued or acknowledged while frozen or in reset; the state holds.
   always_comb begin
      state_nx        = state;
      issue_rd        = 1'b0;
      issue_wr        = 1'b0;
      bus.resp_valid  = 1'b0;
      bus.resp_rdata  = 32'd0;
      mem_a           = 32'd0;
      mem_dout        = 8'd0;
      mem_wr          = 1'b0;
      if (rdy_in && !rst_in) begin
         case (state)
            IDLE: begin
               if (bus.req_valid && !flush_pipline)
                  state_nx = bus.req_we ? WRITE : READ;
            end
            READ: begin
               if (flush_pipline)       state_nx = IDLE;
               else if (idx_q == len_q) state_nx = RESP;
               else                     issue_rd = 1'b1;
            end
            WRITE: begin
               // An IO byte waits for buffer space and never follows another IO byte directly.
               if (!(is_io && (io_buffer_full || io_last_q))) begin
                  issue_wr = 1'b1;
                  if (idx_q == len_q - 3'd1) state_nx = RESP;
               end
            end
            RESP: begin
               bus.resp_valid = 1'b1;
               bus.resp_rdata = rdata_q;
               state_nx       = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
      if (issue_rd || issue_wr) mem_a = byte_addr;
      if (issue_wr) begin
         mem_wr   = 1'b1;
         mem_dout = wdata_q[{idx_q[1:0], 3'b000} +: 8];
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         rdata_q   <= 32'd0;
         len_q     <= 3'd0;
         idx_q     <= 3'd0;
         cap_vld_q <= 1'b0;
         cap_idx_q <= 2'd0;
         io_last_q <= 1'b0;
      end else begin
         io_last_q <= issue_wr && is_io;
         cap_vld_q <= issue_rd;
         cap_idx_q <= idx_q[1:0];
         // Memory answers one cycle late, so capture runs even in the first frozen cycle.
         if (cap_vld_q && state == READ)
            rdata_q[{cap_idx_q, 3'b000} +: 8] <= mem_din;
         if (issue_rd || issue_wr)
            idx_q <= idx_q + 3'd1;
         if (start) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            len_q   <= req_len;
            idx_q   <= 3'd0;
            rdata_q <= 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Directed bench for mem_byte_ctrl with a byte memory model answering one cycle late.
module tb_mem_byte_ctrl;
   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, flush_pipline, io_buffer_full;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr, busy;
   int          n_asrt = 0;
   int          n_fail = 0;

   mem_byte_ctrl_if bus ();

   mem_byte_ctrl dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
      .bus(bus), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full), .busy(busy)
   );

   always #5 clk_in = ~clk_in;

   logic [7:0] mem [65536];
   logic       init_done = 1'b0;

   always @(posedge clk_in) begin
      if (!init_done) begin
         for (int i = 0; i < 65536; i++) mem[i] = i[7:0] ^ 8'h5A;
         mem[16'h1000] = 8'h78;
         mem[16'h1001] = 8'h56;
         mem[16'h1002] = 8'h34;
         mem[16'h1003] = 8'h12;
         init_done <= 1'b1;
      end
      mem_din <= mem[mem_a[15:0]];
      if (mem_wr) mem[mem_a[15:0]] = mem_dout;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_size  = size;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
   endtask

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; flush_pipline = 1'b0; io_buffer_full = 1'b0;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
      bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
      cyc(); cyc();
      chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst_mem_a", mem_a, 32'd0);
      chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
      chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
      rst_in = 1'b0; #1;
      chk("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

      // word read 0x1000
      req(1'b0, 2'd2, 32'h1000, 32'd0); #1;
      cyc(); bus.req_valid = 1'b0; #1;
      for (int k = 0; k < 4; k++) begin
         chk("wrd_rd_addr", mem_a, 32'h1000 + k);
         chk("wrd_rd_wr", {31'd0, mem_wr}, 32'd0);
         chk("wrd_rd_busy", {31'd0, busy}, 32'd1);
         cyc();
      end
      chk("wrd_rd_c5_addr", mem_a, 32'd0);
      chk("wrd_rd_c5_resp", {31'd0, bus.resp_valid}, 32'd0);
      cyc();
      chk("wrd_rd_resp", {31'd0, bus.resp_valid}, 32'd1);
      chk("wrd_rd_data", bus.resp_rdata, 32'h1234_5678);
      cyc();
      chk("wrd_rd_after_resp", {31'd0, bus.resp_valid}, 32'd0);
      chk("wrd_rd_idle_busy", {31'd0, busy}, 32'd0);
      chk("wrd_rd_idle_ready", {31'd0, bus.req_ready}, 32'd1);

      // half write 0x2003, then again with flush held through the write
      for (int f = 0; f < 2; f++) begin
         req(1'b1, 2'd1, 32'h2003 + 32'(f * 16), 32'hAABB_CCDD); #1;
         cyc(); bus.req_valid = 1'b0; flush_pipline = (f == 1); #1;
         chk("hw_c1_addr", mem_a, 32'h2003 + 32'(f * 16));
         chk("hw_c1_dout", {24'd0, mem_dout}, 32'hDD);
         chk("hw_c1_wr", {31'd0, mem_wr}, 32'd1);
         cyc();
         chk("hw_c2_addr", mem_a, 32'h2004 + 32'(f * 16));
         chk("hw_c2_dout", {24'd0, mem_dout}, 32'hCC);
         chk("hw_c2_wr", {31'd0, mem_wr}, 32'd1);
         cyc();
         chk("hw_resp", {31'd0, bus.resp_valid}, 32'd1);
         chk("hw_rdata", bus.resp_rdata, 32'd0);
         chk("hw_c3_wr", {31'd0, mem_wr}, 32'd0);
         cyc(); flush_pipline = 1'b0; #1;
      end
      chk("hw_mem_2013", {24'd0, mem[16'h2013]}, 32'hDD);
      chk("hw_mem_2014", {24'd0, mem[16'h2014]}, 32'hCC);

      // IO byte write stalled by a full buffer
      req(1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041); #1;
      cyc(); bus.req_valid = 1'b0; io_buffer_full = 1'b1; #1;
      for (int k = 0; k < 3; k++) begin
         chk("io_stall_wr", {31'd0, mem_wr}, 32'd0);
         chk("io_stall_addr", mem_a, 32'd0);
         cyc();
      end
      io_buffer_full = 1'b0; #1;
      chk("io_wr", {31'd0, mem_wr}, 32'd1);
      chk("io_addr", mem_a, 32'h0003_0000);
      chk("io_dout", {24'd0, mem_dout}, 32'h41);
      cyc();
      chk("io_resp", {31'd0, bus.resp_valid}, 32'd1);
      chk("io_resp_wr", {31'd0, mem_wr}, 32'd0);
      cyc();

      // IO half write: one idle cycle between the two IO bytes
      req(1'b1, 2'd1, 32'h0003_0010, 32'h0000_BEEF); #1;
      cyc(); bus.req_valid = 1'b0; #1;
      chk("io2_c1_addr", mem_a, 32'h0003_0010);
      chk("io2_c1_dout", {24'd0, mem_dout}, 32'hEF);
      cyc();
      chk("io2_gap_wr", {31'd0, mem_wr}, 32'd0);
      chk("io2_gap_addr", mem_a, 32'd0);
      cyc();
      chk("io2_c3_addr", mem_a, 32'h0003_0011);
      chk("io2_c3_dout", {24'd0, mem_dout}, 32'hBE);
      chk("io2_c3_wr", {31'd0, mem_wr}, 32'd1);
      cyc();
      chk("io2_resp", {31'd0, bus.resp_valid}, 32'd1);
      cyc();

      // half read wrapping the 32-bit address space
      req(1'b0, 2'd1, 32'hFFFF_FFFF, 32'd0); #1;
      cyc(); bus.req_valid = 1'b0; #1;
      chk("wrap_c1_addr", mem_a, 32'hFFFF_FFFF);
      cyc();
      chk("wrap_c2_addr", mem_a, 32'd0);
      cyc(); cyc();
      chk("wrap_resp", {31'd0, bus.resp_valid}, 32'd1);
      chk("wrap_rdata", bus.resp_rdata, 32'h0000_41A5);
      cyc();

      // reserved size read with rdy_in low for two cycles after C2
      req(1'b0, 2'd3, 32'h1000, 32'd0); #1;
      cyc(); bus.req_valid = 1'b0; #1;
      chk("frz_c1_addr", mem_a, 32'h1000);
      cyc();
      chk("frz_c2_addr", mem_a, 32'h1001);
      cyc(); rdy_in = 1'b0; #1;
      for (int k = 0; k < 2; k++) begin
         chk("frz_addr", mem_a, 32'd0);
         chk("frz_resp", {31'd0, bus.resp_valid}, 32'd0);
         chk("frz_busy", {31'd0, busy}, 32'd1);
         cyc();
      end
      rdy_in = 1'b1; #1;
      chk("frz_c5_addr", mem_a, 32'h1002);
      cyc();
      chk("frz_c6_addr", mem_a, 32'h1003);
      chk("frz_c6_resp", {31'd0, bus.resp_valid}, 32'd0);
      cyc();
      chk("frz_c7_addr", mem_a, 32'd0);
      chk("frz_c7_resp", {31'd0, bus.resp_valid}, 32'd0);
      cyc();
      chk("frz_resp_c8", {31'd0, bus.resp_valid}, 32'd1);
      chk("frz_rdata", bus.resp_rdata, 32'h1234_5678);
      cyc();

      // byte read whose RESP is frozen and re-presented
      req(1'b0, 2'd0, 32'h1001, 32'd0); #1;
      cyc(); bus.req_valid = 1'b0; #1;
      chk("rr_c1_addr", mem_a, 32'h1001);
      cyc(); cyc(); rdy_in = 1'b0; #1;
      chk("rr_frozen_resp", {31'd0, bus.resp_valid}, 32'd0);
      cyc(); rdy_in = 1'b1; #1;
      chk("rr_resp", {31'd0, bus.resp_valid}, 32'd1);
      chk("rr_rdata", bus.resp_rdata, 32'h0000_0056);
      cyc();
      chk("rr_done", {31'd0, bus.resp_valid}, 32'd0);

      // flush in C2 of a word read, then a new byte read straight away
      req(1'b0, 2'd2, 32'h1000, 32'd0); #1;
      cyc(); bus.req_valid = 1'b0; #1;
      cyc(); flush_pipline = 1'b1; #1;
      chk("fl_c2_resp", {31'd0, bus.resp_valid}, 32'd0);
      cyc(); flush_pipline = 1'b0; #1;
      chk("fl_idle_busy", {31'd0, busy}, 32'd0);
      chk("fl_idle_ready", {31'd0, bus.req_ready}, 32'd1);
      req(1'b0, 2'd0, 32'h1002, 32'd0); #1;
      cyc(); bus.req_valid = 1'b0; #1;
      chk("fl_new_addr", mem_a, 32'h1002);
      cyc(); cyc();
      chk("fl_new_resp", {31'd0, bus.resp_valid}, 32'd1);
      chk("fl_new_rdata", bus.resp_rdata, 32'h0000_0034);
      cyc();

      // flush and req_valid together in IDLE: not accepted
      req(1'b0, 2'd0, 32'h1000, 32'd0); flush_pipline = 1'b1; #1;
      chk("flreq_ready", {31'd0, bus.req_ready}, 32'd0);
      cyc(); bus.req_valid = 1'b0; flush_pipline = 1'b0; #1;
      chk("flreq_busy", {31'd0, busy}, 32'd0);
      chk("flreq_addr", mem_a, 32'd0);

      // reset in C3 of a word write
      req(1'b1, 2'd2, 32'h2100, 32'h0102_0304); #1;
      cyc(); bus.req_valid = 1'b0; #1;
      chk("rw_c1_dout", {24'd0, mem_dout}, 32'h04);
      cyc();
      chk("rw_c2_dout", {24'd0, mem_dout}, 32'h03);
      cyc(); rst_in = 1'b1; #1;
      chk("rw_rst_ready", {31'd0, bus.req_ready}, 32'd0);
      cyc();
      chk("rw_rst_wr", {31'd0, mem_wr}, 32'd0);
      chk("rw_rst_busy", {31'd0, busy}, 32'd0);
      chk("rw_rst_resp", {31'd0, bus.resp_valid}, 32'd0);
      chk("rw_rst_ready2", {31'd0, bus.req_ready}, 32'd0);
      rst_in = 1'b0; #1;
      chk("rw_ready_back", {31'd0, bus.req_ready}, 32'd1);
      cyc();
      chk("rw_no_resp", {31'd0, bus.resp_valid}, 32'd0);
      chk("rw_mem_2101", {24'd0, mem[16'h2101]}, 32'h03);
      chk("rw_mem_2102", {24'd0, mem[16'h2102]}, 32'h58);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_byte_ctrl.md
MEM_BYTE_CTRL -- requirements
Module: mem_byte_ctrl

Interface
REQ-001 clk_in  in  1  system clock; all state changes on its rising edge.
REQ-002 rst_in  in  1  reset, synchronous and active-high, sampled on rising edge of clk_in.
REQ-003 rdy_in  in  1  global ready; low = freeze.
REQ-004 flush_pipline  in  1  abort any in-progress read.
REQ-005 req_valid  in  1  requester holds a transfer request.
REQ-006 req_ready  out  1  block accepts the request this cycle.
REQ-007 req_we  in  1  1 = write, 0 = read.
REQ-008 req_size  in  2  0 byte, 1 half, 2 word; 3 reserved, treated as word.
REQ-009 req_addr  in  32  first byte address.
REQ-010 req_wdata  in  32  write data, byte k = bits [8k+7:8k].
REQ-011 resp_valid  out  1  one-cycle completion pulse, for both reads and writes.
REQ-012 resp_rdata  out  32  read data, little-endian, zero-extended, 0 for writes.
REQ-013 mem_din  in  8; mem_dout  out  8; mem_a  out  32; mem_wr  out  1 (1 = write): byte-wide memory bus.
REQ-014 io_buffer_full  in  1  uart tx buffer full.
REQ-015 busy  out  1  state != IDLE.

Function
REQ-016 States SHALL be IDLE, READ, WRITE, RESP.
REQ-017 req_ready SHALL equal (state==IDLE) && rdy_in && !flush_pipline && !rst_in.
REQ-018 Handshake: a request is accepted at the edge where req_valid && req_ready; addr, size, we and wdata are latched then; n = 1/2/4 bytes.
REQ-019 READ: in cycles C1..Cn after acceptance, drive mem_a = addr+k (k = 0..n-1, 32-bit wrap) and mem_wr=0; misalignment is permitted.
REQ-020 Memory returns data one cycle after the address, so byte k SHALL be captured from mem_din at the end of cycle C(k+2) into bits [8k+7:8k].
REQ-021 After the last capture, state SHALL be RESP for one cycle: resp_valid=1, resp_rdata valid. Read latency is n+2 cycles from acceptance to the resp_valid cycle.
REQ-022 WRITE: in cycle Ck drive mem_a = addr+k, mem_dout = byte k, mem_wr=1. After the last byte, enter RESP (resp_valid=1, resp_rdata=0).
REQ-023 IO write stall: for an address with addr[17:16]==2'b11, a byte SHALL NOT be issued while io_buffer_full=1, nor in the cycle directly after another IO write byte.
REQ-024 During an IO write stall: mem_wr=0, mem_a=0, byte index held.
REQ-025 When not issuing (IDLE, RESP, stall, last capture cycle): mem_a=0, mem_wr=0, mem_dout=0, so that no IO address is read twice.
REQ-026 rdy_in low: FSM, byte index and latched request SHALL hold; mem_a=0, mem_wr=0, resp_valid=0.
REQ-027 A byte whose address was driven in the preceding ready cycle SHALL still be captured in the first rdy-low cycle.
REQ-028 On resume, issuing continues at the next un-issued byte.
REQ-029 A RESP interrupted by rdy_in low SHALL be re-presented when rdy_in returns.
REQ-030 flush_pipline in READ: return to IDLE next cycle with no resp_valid; pending captures are discarded.
REQ-031 flush_pipline in WRITE or RESP SHALL be ignored; writes always complete and acknowledge.
REQ-032 RESP always returns to IDLE; a new request may be accepted in the cycle after RESP.
REQ-033 flush_pipline and req_valid in the same IDLE cycle: the request is not accepted.

Reset
REQ-034 rst_in high at an edge SHALL force IDLE regardless of state or rdy_in, aborting any transfer mid-operation.
REQ-035 Reset values: req_ready=0 during reset, resp_valid=0, resp_rdata=0, mem_a=0, mem_dout=0, mem_wr=0, busy=0, all internal registers 0.
REQ-036 req_ready rises in the first cycle after rst_in falls, provided rdy_in=1.

Verification
REQ-037 Word read at 0x1000, memory holds 0x78,0x56,0x34,0x12 -> mem_a 0x1000..0x1003 in C1..C4, resp_valid in C6, resp_rdata=0x12345678.
REQ-038 Half write at 0x2003 with wdata 0xAABBCCDD -> C1: mem_a=0x2003, mem_dout=0xDD, mem_wr=1; C2: 0x2004, 0xCC; resp_valid in C3.
REQ-039 Byte write 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 during those cycles, then one write of 0x41, then resp_valid.
REQ-040 Word read with rdy_in low for 2 cycles after C2 -> exactly 4 distinct read addresses issued, resp_rdata correct, resp_valid delayed by 2 cycles.
REQ-041 flush_pipline in C2 of a word read -> no resp_valid, IDLE next cycle, next request accepted; flush during a half write -> both bytes written and acknowledged.
REQ-042 rst_in asserted in C3 of a word write -> next cycle mem_wr=0, busy=0, no resp_valid, req_ready=0 while rst_in is high.
